// File: rtl/ppu_pkg.sv
// Shared geometry, derived widths and types for the PPU background renderer.
package ppu_pkg;

  localparam int unsigned ROW_PIXELS_D = 320;
  localparam int unsigned TILE_W_D     = 8;
  localparam int unsigned MAP_W_D      = 64;
  localparam int unsigned MAP_H_D      = 64;
  localparam int unsigned PAT_BPP_D    = 4;
  localparam int unsigned PAL_ID_W_D   = 6;
  localparam int unsigned PAT_IDX_W_D  = 10;

  localparam int unsigned COL_W_D        = $clog2(TILE_W_D);
  localparam int unsigned X_W_D          = $clog2(MAP_W_D * TILE_W_D);
  localparam int unsigned Y_W_D          = $clog2(MAP_H_D * TILE_W_D);
  localparam int unsigned PIX_W_D        = $clog2(ROW_PIXELS_D);
  localparam int unsigned TILE_ADDR_W_D  = $clog2(MAP_W_D * MAP_H_D);
  localparam int unsigned PAT_ADDR_W_D   = PAT_IDX_W_D + COL_W_D;
  localparam int unsigned TILE_ENTRY_W_D = PAL_ID_W_D + PAT_IDX_W_D;
  localparam int unsigned PAT_ROW_W_D    = TILE_W_D * PAT_BPP_D;
  localparam int unsigned ROW_DATA_W_D   = PAL_ID_W_D + PAT_BPP_D;

  typedef struct packed {
    logic [PAL_ID_W_D-1:0]  pal_id;
    logic [PAT_IDX_W_D-1:0] pat_idx;
  } tile_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_TILE,
    S_FETCH_PAT,
    S_LOAD,
    S_EMIT,
    S_DONE
  } render_state_t;

endpackage

// File: rtl/ppu_bg_row_renderer_if.sv
// Control, VRAM read and row-RAM write signals of the background row renderer.
interface ppu_bg_row_renderer_if
  import ppu_pkg::*;
#(
  parameter int unsigned PIX_W        = PIX_W_D,
  parameter int unsigned X_W          = X_W_D,
  parameter int unsigned Y_W          = Y_W_D,
  parameter int unsigned TILE_ADDR_W  = TILE_ADDR_W_D,
  parameter int unsigned TILE_ENTRY_W = TILE_ENTRY_W_D,
  parameter int unsigned PAT_ADDR_W   = PAT_ADDR_W_D,
  parameter int unsigned PAT_ROW_W    = PAT_ROW_W_D,
  parameter int unsigned ROW_DATA_W   = ROW_DATA_W_D
);

  logic                    start;
  logic [Y_W-1:0]          row_y;
  logic [X_W-1:0]          scroll_x;
  logic [Y_W-1:0]          scroll_y;
  logic                    busy;
  logic                    done;
  logic [TILE_ADDR_W-1:0]  tile_rdaddr;
  logic [TILE_ENTRY_W-1:0] tile_rddata;
  logic [PAT_ADDR_W-1:0]   pat_rdaddr;
  logic [PAT_ROW_W-1:0]    pat_rddata;
  logic [PIX_W-1:0]        rowram_wraddr;
  logic [ROW_DATA_W-1:0]   rowram_wrdata;
  logic                    rowram_wren;

  // System side: issues requests, serves VRAM reads, sinks row-RAM writes.
  modport master (
    output start, row_y, scroll_x, scroll_y, tile_rddata, pat_rddata,
    input  busy, done, tile_rdaddr, pat_rdaddr,
           rowram_wraddr, rowram_wrdata, rowram_wren
  );

  // Renderer side.
  modport slave (
    input  start, row_y, scroll_x, scroll_y, tile_rddata, pat_rddata,
    output busy, done, tile_rdaddr, pat_rdaddr,
           rowram_wraddr, rowram_wrdata, rowram_wren
  );

endinterface

// File: rtl/ppu_bg_row_renderer.sv
// Background row renderer: walks the scrolled tile map for one scanline and
// writes one {palette id, colour} row-RAM entry per visible pixel.
module ppu_bg_row_renderer
  import ppu_pkg::*;
#(
  parameter int unsigned ROW_PIXELS = ROW_PIXELS_D,
  parameter int unsigned TILE_W     = TILE_W_D,
  parameter int unsigned MAP_W      = MAP_W_D,
  parameter int unsigned MAP_H      = MAP_H_D,
  parameter int unsigned PAT_BPP    = PAT_BPP_D,
  parameter int unsigned PAL_ID_W   = PAL_ID_W_D,
  parameter int unsigned PAT_IDX_W  = PAT_IDX_W_D
) (
  input logic                 clk,
  input logic                 rst,
  ppu_bg_row_renderer_if.slave bus
);

  localparam int unsigned COL_W     = $clog2(TILE_W);
  localparam int unsigned X_W       = $clog2(MAP_W * TILE_W);
  localparam int unsigned Y_W       = $clog2(MAP_H * TILE_W);
  localparam int unsigned PIX_W     = $clog2(ROW_PIXELS);
  localparam int unsigned PAT_ROW_W = TILE_W * PAT_BPP;

  render_state_t state, state_nxt;

  logic [Y_W-1:COL_W]   ty;
  logic [COL_W-1:0]     line;
  logic [X_W-1:0]       ex;
  logic [PIX_W-1:0]     p;
  logic [PAL_ID_W-1:0]  pal_q;
  logic [PAT_ROW_W-1:0] word_q;

  logic [Y_W-1:0]       ey_c;
  logic [COL_W-1:0]     col_c;
  logic [PAT_BPP-1:0]   colour_c;
  logic                 last_pix_c;
  logic                 tile_end_c;

  assign ey_c       = bus.row_y + bus.scroll_y;
  assign col_c      = ex[COL_W-1:0];
  assign colour_c   = word_q[PAT_BPP*col_c +: PAT_BPP];
  assign last_pix_c = (p == PIX_W'(ROW_PIXELS - 1));
  assign tile_end_c = (col_c == COL_W'(TILE_W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (bus.start) state_nxt = S_FETCH_TILE;
      S_FETCH_TILE: state_nxt = S_FETCH_PAT;
      S_FETCH_PAT:  state_nxt = S_LOAD;
      S_LOAD:       state_nxt = S_EMIT;
      S_EMIT: begin
        if (last_pix_c)      state_nxt = S_DONE;
        else if (tile_end_c) state_nxt = S_FETCH_TILE;
      end
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Row coordinates are latched on acceptance; ex advances one pixel per write
  // and wraps around the map by truncation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ty     <= '0;
      line   <= '0;
      ex     <= '0;
      p      <= '0;
      pal_q  <= '0;
      word_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          ty   <= ey_c[Y_W-1:COL_W];
          line <= ey_c[COL_W-1:0];
          ex   <= bus.scroll_x;
          p    <= '0;
        end
        S_FETCH_PAT: pal_q  <= bus.tile_rddata[PAT_IDX_W +: PAL_ID_W];
        S_LOAD:      word_q <= bus.pat_rddata;
        S_EMIT: begin
          ex <= ex + X_W'(1);
          p  <= p + PIX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state and datapath registers.
  always_comb begin
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.tile_rdaddr   = '0;
    bus.pat_rdaddr    = '0;
    bus.rowram_wren   = 1'b0;
    bus.rowram_wraddr = '0;
    bus.rowram_wrdata = '0;
    case (state)
      S_FETCH_TILE: begin
        bus.busy        = 1'b1;
        bus.tile_rdaddr = {ty, ex[X_W-1:COL_W]};
      end
      S_FETCH_PAT: begin
        bus.busy       = 1'b1;
        bus.pat_rdaddr = {bus.tile_rddata[PAT_IDX_W-1:0], line};
      end
      S_LOAD: bus.busy = 1'b1;
      S_EMIT: begin
        bus.busy          = 1'b1;
        bus.rowram_wren   = 1'b1;
        bus.rowram_wraddr = p;
        // Colour 0 is transparent and hides the palette id.
        bus.rowram_wrdata = (colour_c == '0) ? '0 : {pal_q, colour_c};
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
